// File: rtl/serial_pkg.sv
// Shared serial framing types and line constants for the transmit and receive framers.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Divides the clock into serial bit periods; tick marks the last clock of each bit.
module bit_tick_counter #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LastCnt);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits, optional parity, stop bit.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pIn,
  input  logic             load,
  output logic             ready,
  output logic             sOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             parity_q, parity_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             tick, accept;

  function automatic logic cur_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign busy    = (state_q != S_IDLE);
  assign ready   = ~busy;
  assign accept  = load & ready;
  assign sOut    = sout_q;
  assign done    = done_q;
  assign shifted = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  bit_tick_counter #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clear(accept),
    .tick (tick)
  );

  // sout_d carries the line level of the state being entered, so sOut is registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    sout_d    = sout_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          shift_d  = pIn;
          parity_d = (^pIn) ^ PARITY_ODD;
          sout_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          sout_d  = cur_bit(shift_q);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shifted;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            if (PARITY_EN) begin
              state_d = S_PARITY;
              sout_d  = parity_q;
            end else begin
              state_d = S_STOP;
              sout_d  = LINE_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            sout_d    = cur_bit(shifted);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          sout_d  = LINE_IDLE;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          sout_d  = LINE_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sout_d  = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      sout_q    <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      sout_q    <= sout_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: frame-level model per instance plus directed literal frames.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pIn0, pIn1;
  logic       load0, load1;
  logic       so[2], rd[2], bs[2], dn[2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: each accepted word becomes a flat array of per-clock line levels.
  bit fr[2][64];
  int len[2];
  int pos[2];
  bit inf[2];
  bit done_e[2];

  always #5 clk = ~clk;

  serial_frame_tx u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .pIn  (pIn0),
    .load (load0),
    .ready(rd[0]),
    .sOut (so[0]),
    .busy (bs[0]),
    .done (dn[0])
  );

  serial_frame_tx #(
    .WIDTH     (8),
    .BIT_CYCLES(3),
    .MSB_FIRST (1'b1),
    .PARITY_EN (1'b0),
    .PARITY_ODD(1'b0)
  ) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .pIn  (pIn1),
    .load (load1),
    .ready(rd[1]),
    .sOut (so[1]),
    .busy (bs[1]),
    .done (dn[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, k, $time, got, exp);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit ld, input logic [7:0] w);
    int bc;
    bit pen;
    bit msb;
    bit b[12];
    int nb;
    bc  = (k == 1) ? 3 : 1;
    msb = (k == 1);
    pen = (k == 0);
    if (r) begin
      inf[k]    = 1'b0;
      done_e[k] = 1'b0;
    end else if (inf[k]) begin
      pos[k]++;
      if (pos[k] == len[k]) begin
        inf[k]    = 1'b0;
        done_e[k] = 1'b1;
      end
    end else begin
      done_e[k] = 1'b0;
      if (ld) begin
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = msb ? w[7-i] : w[i];
        nb = 9;
        if (pen) begin
          b[nb] = ^w;
          nb++;
        end
        b[nb] = 1'b1;
        nb++;
        len[k] = nb * bc;
        for (int j = 0; j < len[k]; j++) fr[k][j] = b[j/bc];
        pos[k] = 0;
        inf[k] = 1'b1;
      end
    end
  endtask

  function automatic logic mexp(input int k);
    return inf[k] ? fr[k][pos[k]] : 1'b1;
  endfunction

  always @(posedge clk) begin
    model_step(0, rst, load0, pIn0);
    model_step(1, rst, load1, pIn1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("sOut", k, 32'(so[k]), 32'(mexp(k)));
        chk("ready", k, 32'(rd[k]), 32'(!inf[k]));
        chk("busy", k, 32'(bs[k]), 32'(inf[k]));
        chk("done", k, 32'(dn[k]), 32'(done_e[k]));
      end
    end
  end

  // pat[n-1] is the first bit on the line; each bit is checked on all bc clocks.
  task automatic expect_seq(input string nm, input int k, input logic [31:0] pat, input int n,
                            input int bc, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < bc; c++) begin
        @(negedge clk);
        if (c == bc / 2) got = {got[30:0], so[k]};
        chk(nm, k, 32'(so[k]), 32'(pat[n-1-i]));
        chk({nm, "_model"}, k, 32'(mexp(k)), 32'(pat[n-1-i]));
      end
    end
  endtask

  task automatic send0(input logic [7:0] w);
    @(posedge clk);
    #1;
    load0 = 1'b1;
    pIn0  = w;
    @(posedge clk);
    #1;
    load0 = 1'b0;
    pIn0  = 8'($urandom);
  endtask

  logic [31:0] g;

  initial begin
    load0 = 1'b1;
    pIn0  = 8'hA5;
    load1 = 1'b1;
    pIn1  = 8'h80;

    // 1: reset with load held
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_sOut", k, 32'(so[k]), 32'd1);
      chk("rst_ready", k, 32'(rd[k]), 32'd1);
      chk("rst_busy", k, 32'(bs[k]), 32'd0);
      chk("rst_done", k, 32'(dn[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    load0 = 1'b0;
    load1 = 1'b0;
    @(negedge clk);
    chk("post_rst_sOut", 0, 32'(so[0]), 32'd1);

    // 2: single frame
    send0(8'hA5);
    expect_seq("t2_A5", 0, 32'b01010010101, 11, 1, g);
    @(negedge clk);
    chk("t2_done", 0, 32'(dn[0]), 32'd1);
    repeat (3) @(posedge clk);

    // 3: back-to-back via held load accepted on the done cycle
    @(posedge clk);
    #1;
    load0 = 1'b1;
    pIn0  = 8'h01;
    @(posedge clk);
    #1 pIn0 = 8'hFF;
    expect_seq("t3_01", 0, 32'b01000000011, 11, 1, g);
    @(negedge clk);
    chk("t3_done_a", 0, 32'(dn[0]), 32'd1);
    chk("t3_ready_a", 0, 32'(rd[0]), 32'd1);
    @(posedge clk);
    #1 load0 = 1'b0;
    expect_seq("t3_FF", 0, 32'b01111111101, 11, 1, g);
    @(negedge clk);
    chk("t3_done_b", 0, 32'(dn[0]), 32'd1);
    repeat (3) @(posedge clk);

    // 4: load/pIn disturbed mid-frame
    send0(8'h5A);
    fork
      expect_seq("t4_5A", 0, 32'b00101101001, 11, 1, g);
      begin
        repeat (2) @(posedge clk);
        #1;
        load0 = 1'b1;
        pIn0  = 8'hFF;
        @(posedge clk);
        #1;
        load0 = 1'b0;
        pIn0  = 8'h00;
        @(posedge clk);
        #1 load0 = 1'b1;
        @(posedge clk);
        #1 load0 = 1'b0;
      end
    join
    @(negedge clk);
    chk("t4_done", 0, 32'(dn[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_no_extra", 0, 32'(bs[0]), 32'd0);

    // 5: reset during the 4th data bit
    send0(8'hC3);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_sOut", 0, 32'(so[0]), 32'd1);
    chk("t5_ready", 0, 32'(rd[0]), 32'd1);
    chk("t5_done", 0, 32'(dn[0]), 32'd0);
    send0(8'h3C);
    expect_seq("t5_3C", 0, 32'b00011110001, 11, 1, g);
    @(negedge clk);
    chk("t5_done_after", 0, 32'(dn[0]), 32'd1);

    // 6: 3 clocks per bit, MSB first, no parity
    @(posedge clk);
    #1;
    load1 = 1'b1;
    pIn1  = 8'h80;
    @(posedge clk);
    #1;
    load1 = 1'b0;
    pIn1  = 8'h00;
    expect_seq("t6_80", 1, 32'b0100000001, 10, 3, g);
    chk("t6_po", 1, {24'd0, g[8:1]}, 32'h80);
    @(negedge clk);
    chk("t6_done", 1, 32'(dn[1]), 32'd1);

    // Random traffic on both instances, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      load0 = ($urandom_range(0, 3) == 0);
      pIn0  = 8'($urandom);
      load1 = ($urandom_range(0, 7) == 0);
      pIn1  = 8'($urandom);
      rst   = ($urandom_range(0, 249) == 0);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    load0 = 1'b0;
    load1 = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
